// File: rtl/tone_pkg.sv
// Shared types, widths and the phase-to-waveform mapping for the tone oscillator.
package tone_pkg;

  localparam int SAMPLE_W = 16;
  localparam int PHASE_W  = 32;
  localparam int AMP_W    = 8;

  localparam logic [AMP_W-1:0] AMP_MAX = '1;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SILENT = 2'd3
  } wave_sel_t;

  typedef enum logic [1:0] {
    ENV_IDLE    = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_t;

  // acc_top is acc[31:15]; the lower phase bits never reach the waveform.
  function automatic logic [SAMPLE_W-1:0] wave_lookup(input wave_sel_t sel,
                                                      input logic [16:0] acc_top);
    logic [15:0] fold;
    logic [SAMPLE_W-1:0] result;
    fold = acc_top[16] ? ~acc_top[15:0] : acc_top[15:0];
    case (sel)
      WAVE_SQUARE: result = acc_top[16] ? 16'h8000 : 16'h7fff;
      WAVE_SAW:    result = {~acc_top[16], acc_top[15:1]};
      WAVE_TRI:    result = {~fold[15], fold[14:0]};
      default:     result = '0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/tone_env.sv
// ADSR-style envelope (no decay) advancing only on sample ticks; amp saturates at 0 and 255.
module tone_env
  import tone_pkg::*;
#(
  parameter int ATTACK_STEP  = 8,
  parameter int RELEASE_STEP = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             tick,
  input  logic             gate,
  output logic [AMP_W-1:0] amp,
  output env_state_t       state,
  output logic             release_done
);

  localparam logic [AMP_W:0] ATK = (AMP_W+1)'(ATTACK_STEP);
  localparam logic [AMP_W:0] REL = (AMP_W+1)'(RELEASE_STEP);

  logic [AMP_W:0] attack_sum;
  logic           attack_full;
  logic           release_empty;

  assign attack_sum    = {1'b0, amp} + ATK;
  assign attack_full   = attack_sum >= {1'b0, AMP_MAX};
  assign release_empty = {1'b0, amp} <= REL;

  // Lets the top clear the phase accumulator on the same tick that the envelope dies.
  assign release_done = tick && (state == ENV_RELEASE) && !gate && release_empty;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= ENV_IDLE;
      amp   <= '0;
    end else if (tick) begin
      case (state)
        ENV_IDLE: begin
          if (gate) begin
            amp   <= attack_full ? AMP_MAX : attack_sum[AMP_W-1:0];
            state <= attack_full ? ENV_SUSTAIN : ENV_ATTACK;
          end else begin
            amp <= '0;
          end
        end
        ENV_ATTACK: begin
          if (!gate) begin
            state <= ENV_RELEASE;
          end else begin
            amp   <= attack_full ? AMP_MAX : attack_sum[AMP_W-1:0];
            state <= attack_full ? ENV_SUSTAIN : ENV_ATTACK;
          end
        end
        ENV_SUSTAIN: begin
          amp <= AMP_MAX;
          if (!gate) state <= ENV_RELEASE;
        end
        default: begin
          if (gate) begin
            state <= ENV_ATTACK;
          end else if (release_empty) begin
            amp   <= '0;
            state <= ENV_IDLE;
          end else begin
            amp <= amp - REL[AMP_W-1:0];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/tone_osc.sv
// Phase-accumulator tone oscillator with 2-cycle amplitude pipeline.
// Define TONE_OSC_ENVELOPE_EN to use the tone_env envelope instead of a plain gate.
module tone_osc
  import tone_pkg::*;
#(
  parameter int ATTACK_STEP  = 8,
  parameter int RELEASE_STEP = 4
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [PHASE_W-1:0]  phase_incr_in,
  input  logic                note_on_in,
  input  logic                sample_tick_in,
  input  logic [1:0]          wave_sel_in,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid_out,
  output logic [1:0]          env_state_out
);

  logic [PHASE_W-1:0] acc_reg;
  logic [AMP_W-1:0]   amp_cur;
  env_state_t         state_cur;
  logic               acc_clear;

`ifdef TONE_OSC_ENVELOPE_EN
  logic release_done;

  tone_env #(
    .ATTACK_STEP (ATTACK_STEP),
    .RELEASE_STEP(RELEASE_STEP)
  ) u_env (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .tick        (sample_tick_in),
    .gate        (note_on_in),
    .amp         (amp_cur),
    .state       (state_cur),
    .release_done(release_done)
  );

  assign acc_clear = (state_cur == ENV_IDLE) || release_done;
`else
  localparam int unused_steps = ATTACK_STEP + RELEASE_STEP;

  env_state_t gate_state_reg;

  // The gate itself is the amplitude; only the debug state is registered.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      gate_state_reg <= ENV_IDLE;
    end else if (sample_tick_in) begin
      gate_state_reg <= note_on_in ? ENV_SUSTAIN : ENV_IDLE;
    end
  end

  assign amp_cur   = note_on_in ? AMP_MAX : '0;
  assign state_cur = gate_state_reg;
  assign acc_clear = !note_on_in;
`endif

  assign env_state_out = state_cur;

  logic [16:0]         snap_top_reg;
  wave_sel_t           snap_sel_reg;
  logic [AMP_W-1:0]    snap_amp_reg;
  logic                snap_valid_reg;
  logic [SAMPLE_W-1:0] wave1_reg;
  logic [AMP_W-1:0]    amp1_reg;
  logic                valid1_reg;
  logic [SAMPLE_W-1:0] sample_reg;
  logic                sample_valid_reg;

  logic signed [23:0]  product;
  logic                unused_product_bits;

  // Amp is unsigned, so it gets a zero sign bit before the signed multiply.
  assign product             = $signed(wave1_reg) * $signed({1'b0, amp1_reg});
  assign unused_product_bits = ^product[7:0];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc_reg          <= '0;
      snap_top_reg     <= '0;
      snap_sel_reg     <= WAVE_SILENT;
      snap_amp_reg     <= '0;
      snap_valid_reg   <= 1'b0;
      wave1_reg        <= '0;
      amp1_reg         <= '0;
      valid1_reg       <= 1'b0;
      sample_reg       <= '0;
      sample_valid_reg <= 1'b0;
    end else begin
      snap_valid_reg <= sample_tick_in;
      if (sample_tick_in) begin
        acc_reg      <= acc_clear ? '0 : acc_reg + phase_incr_in;
        snap_top_reg <= acc_reg[31:15];
        snap_sel_reg <= wave_sel_t'(wave_sel_in);
        snap_amp_reg <= amp_cur;
      end

      valid1_reg <= snap_valid_reg;
      if (snap_valid_reg) begin
        wave1_reg <= wave_lookup(snap_sel_reg, snap_top_reg);
        amp1_reg  <= snap_amp_reg;
      end

      sample_valid_reg <= valid1_reg;
      if (valid1_reg) sample_reg <= product[23:8];
    end
  end

  assign sample_out       = sample_reg;
  assign sample_valid_out = sample_valid_reg;

endmodule

// File: doc/tone_osc.md
TONE_OSC -- requirements
Module: tone_osc

Interface
REQ-001 Parameter ATTACK_STEP, default 8, amplitude increment per sample tick in ATTACK (1..255).
REQ-002 Parameter RELEASE_STEP, default 4, amplitude decrement per sample tick in RELEASE (1..255).
REQ-003 clk_in  input  1  system clock; one clock domain.
REQ-004 rst_n_in  input  1  asynchronous, active-low reset.
REQ-005 phase_incr_in  input  32  phase increment from the tone lookup stage; sampled only on sample_tick_in.
REQ-006 note_on_in  input  1  gate; high = note held.
REQ-007 sample_tick_in  input  1  one-cycle sample-rate strobe; back-to-back ticks legal.
REQ-008 wave_sel_in  input  2  0 square, 1 saw, 2 triangle, 3 silence; sampled on tick.
REQ-009 sample_out  output  16  signed audio sample, held between valid pulses.
REQ-010 sample_valid_out  output  1  one-cycle pulse when sample_out updates.
REQ-011 env_state_out  output  2  current envelope state encoding (debug).

Function
REQ-012 On the tick at edge N: acc <= acc + phase_incr_in, modulo 2^32; wave and amp computed from pre-update acc and amp.
REQ-013 Wave mapping from acc (pre-update): square = acc[31] ? -32768 : +32767; saw = {~acc[31], acc[30:16]}; triangle = {~t[15], t[14:0]} where t = acc[31] ? ~acc[30:15] : acc[30:15]; silence = 0.
REQ-014 Stage 1 registers wave and amp at edge N+1; stage 2 computes signed wave times unsigned 8-bit amp (24-bit product), takes product[23:8] (arithmetic truncation), registers sample_out and pulses sample_valid_out at edge N+2; fixed latency 2 cycles, fully pipelined.
REQ-015 Envelope FSM states IDLE(0), ATTACK(1), SUSTAIN(2), RELEASE(3); transitions evaluated only on ticks.
REQ-016 IDLE: amp = 0, acc held at 0 (increment suppressed); note_on_in high -> ATTACK.
REQ-017 ATTACK: amp += ATTACK_STEP, saturating at 255; reaching 255 -> SUSTAIN; note_on_in low -> RELEASE (no increment on that tick).
REQ-018 SUSTAIN: amp = 255; note_on_in low -> RELEASE.
REQ-019 RELEASE: amp -= RELEASE_STEP, saturating at 0; reaching 0 -> IDLE and acc cleared to 0; note_on_in high -> ATTACK from current amp.
REQ-020 phase_incr_in = 0 is legal: acc holds, output constant.
REQ-021 Outputs never change between ticks except sample_valid_out deassertion.

Reset
REQ-022 Assertion of rst_n_in immediately clears acc, amp, pipeline registers, sample_out = 0, sample_valid_out = 0, state IDLE.
REQ-023 A tick in flight when reset asserts produces no valid pulse; first tick after release behaves as from IDLE.

Configuration
REQ-024 Macro TONE_OSC_ENVELOPE_EN defined: FSM per REQ-015..019.
REQ-025 Macro undefined: no FSM; amp = note_on_in ? 255 : 0 sampled on tick; acc held at 0 while note_on_in low; env_state_out = note_on_in ? SUSTAIN : IDLE.

Structure
REQ-026 Shared package tone_pkg holds wave_sel enum, env_state enum, SAMPLE_W = 16, PHASE_W = 32, AMP_W = 8.
REQ-027 Envelope FSM lives in sub-module tone_env (inputs tick, gate; outputs amp, state), instantiated only under TONE_OSC_ENVELOPE_EN.

Verification
REQ-028 Reset: rst_n_in low -> sample_out = 0, sample_valid_out = 0, env_state_out = 0 without clock edge.
REQ-029 Macro undefined, incr = 0x40000000, square, note held, 4 ticks -> samples 32639, 32639, -32640, -32640, each 2 cycles after its tick.
REQ-030 Wrap: incr = 0xC0000000, note held -> acc 0, 0xC0000000, 0x80000000, 0x40000000, 0x00000000.
REQ-031 Macro defined, ATTACK_STEP = 64, note held -> amp 64, 128, 192, 255 after ticks 1..4; SUSTAIN after tick 4.
REQ-032 Macro defined, RELEASE_STEP = 4, note drops at amp 128 -> RELEASE, IDLE after 32 ticks, acc = 0.
REQ-033 Reset asserted one cycle after a tick -> no sample_valid_out pulse, sample_out stays 0.
